// File: rtl/saf_cg_scheduler_if.sv
// Handshake and enable-vector bundle for saf_cg_scheduler.
// master: sample source / error datapath side; slave: the scheduler.
interface saf_cg_scheduler_if #(
    parameter int LENGTH = 16,
    parameter int NCP    = 32,
    parameter int SPAN_W = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              err_valid;
    logic [SPAN_W-1:0] span_idx;
    logic [LENGTH-1:0] dl_cg_en;
    logic [LENGTH-1:0] w_cg_en;
    logic [NCP-1:0]    cp_cg_en;
    logic              done;
    logic [15:0]       sample_cnt;

    modport master (
        output flush, in_valid, err_valid, span_idx,
        input  in_ready, dl_cg_en, w_cg_en, cp_cg_en, done, sample_cnt
    );

    modport slave (
        input  flush, in_valid, err_valid, span_idx,
        output in_ready, dl_cg_en, w_cg_en, cp_cg_en, done, sample_cnt
    );
endinterface

// File: rtl/saf_cg_scheduler.sv
// Per-sample sequencing of clock-gate enables for the spline adaptive filter:
// delay-line shift, then (after the error arrives) an update of the four
// control points around the current span plus the linear weights.
// Optional macro SAF_SEQ_PU_EN: sequential partial update, enabling one
// PU_BLOCK-wide weight block per sample in round-robin order.
module saf_cg_scheduler #(
    parameter int LENGTH   = 16,
    parameter int NCP      = 32,
    parameter int SPAN_W   = 5,
    parameter int PU_BLOCK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    saf_cg_scheduler_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT_ERR, UPDATE, DONE} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [LENGTH-1:0] dl_q, dl_d;
    logic [LENGTH-1:0] w_q, w_d;
    logic [NCP-1:0]    cp_q, cp_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [SPAN_W-1:0] base;

`ifdef SAF_SEQ_PU_EN
    localparam int NBLK  = LENGTH / PU_BLOCK;
    localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;

    logic [BLK_W-1:0] blk_q, blk_d;
`endif

    // Clamp the span so the 4-point window never runs past the last point
    always_comb begin
        base = bus.span_idx;
        if (int'(bus.span_idx) > NCP - 4) base = SPAN_W'(NCP - 4);
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (bus.in_valid && in_ready_q) state_d = SHIFT;
            SHIFT:    state_d = WAIT_ERR;
            WAIT_ERR: if (bus.err_valid) state_d = UPDATE;
            UPDATE:   state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // Outputs are registered, so they are decoded from the next state;
    // span_idx is thereby captured on the err_valid cycle
    always_comb begin
        in_ready_d = (state_d == IDLE);
        dl_d       = (state_d == SHIFT) ? '1 : '0;
        done_d     = (state_d == DONE);
        cnt_d      = cnt_q + 16'(state_d == DONE);
        cp_d       = '0;
        for (int unsigned i = 0; i < NCP; i++) begin
            cp_d[i] = (state_d == UPDATE) && (i >= 32'(base)) && (i < 32'(base) + 4);
        end
`ifdef SAF_SEQ_PU_EN
        w_d   = '0;
        blk_d = blk_q;
        for (int unsigned i = 0; i < LENGTH; i++) begin
            w_d[i] = (state_d == UPDATE) && ((i / PU_BLOCK) == 32'(blk_q));
        end
        if (state_d == DONE) begin
            blk_d = (blk_q == BLK_W'(NBLK - 1)) ? '0 : blk_q + 1'b1;
        end
`else
        w_d = (state_d == UPDATE) ? '1 : '0;
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            dl_q       <= '0;
            w_q        <= '0;
            cp_q       <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            dl_q       <= dl_d;
            w_q        <= w_d;
            cp_q       <= cp_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef SAF_SEQ_PU_EN
    // Round-robin weight-block pointer
    always_ff @(posedge clk) begin
        if (!reset) blk_q <= '0;
        else        blk_q <= blk_d;
    end
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.dl_cg_en   = dl_q;
    assign bus.w_cg_en    = w_q;
    assign bus.cp_cg_en   = cp_q;
    assign bus.done       = done_q;
    assign bus.sample_cnt = cnt_q;

endmodule
